// File: rtl/sdram_mc_fifo_arbiter_if.sv
// Bus bundle between the multi-channel SDRAM FIFO arbiter and its surroundings:
// per-channel configuration/status in, controller request/ack and FIFO strobes.
interface sdram_mc_fifo_arbiter_if #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 24,
    parameter int LEN_W  = 10,
    parameter int USE_W  = 10
);
    logic                             sdram_init_done;
    logic [NUM_CH-1:0]                wr_load;
    logic [NUM_CH-1:0]                rd_load;
    logic [NUM_CH-1:0]                read_valid;
    logic [NUM_CH-1:0]                pingpang_en;
    logic [NUM_CH-1:0][ADDR_W-1:0]    wr_min_addr;
    logic [NUM_CH-1:0][ADDR_W-1:0]    wr_max_addr;
    logic [NUM_CH-1:0][ADDR_W-1:0]    rd_min_addr;
    logic [NUM_CH-1:0][ADDR_W-1:0]    rd_max_addr;
    logic [NUM_CH-1:0][LEN_W-1:0]     wr_length;
    logic [NUM_CH-1:0][LEN_W-1:0]     rd_length;
    logic [NUM_CH-1:0][USE_W-1:0]     wrf_use;
    logic [NUM_CH-1:0][USE_W-1:0]     rdf_use;
    logic                             sdram_wr_req;
    logic                             sdram_wr_ack;
    logic [ADDR_W-1:0]                sdram_wr_addr;
    logic                             sdram_rd_req;
    logic                             sdram_rd_ack;
    logic [ADDR_W-1:0]                sdram_rd_addr;
    logic [NUM_CH-1:0]                grant;
    logic [NUM_CH-1:0]                wrf_rdreq;
    logic [NUM_CH-1:0]                rdf_wrreq;

    modport master (
        input  sdram_init_done, wr_load, rd_load, read_valid, pingpang_en,
               wr_min_addr, wr_max_addr, rd_min_addr, rd_max_addr,
               wr_length, rd_length, wrf_use, rdf_use, sdram_wr_ack, sdram_rd_ack,
        output sdram_wr_req, sdram_wr_addr, sdram_rd_req, sdram_rd_addr,
               grant, wrf_rdreq, rdf_wrreq
    );

    modport slave (
        output sdram_init_done, wr_load, rd_load, read_valid, pingpang_en,
               wr_min_addr, wr_max_addr, rd_min_addr, rd_max_addr,
               wr_length, rd_length, wrf_use, rdf_use, sdram_wr_ack, sdram_rd_ack,
        input  sdram_wr_req, sdram_wr_addr, sdram_rd_req, sdram_rd_addr,
               grant, wrf_rdreq, rdf_wrreq
    );
endinterface

// File: rtl/sdram_mc_fifo_arbiter.sv
// Multi-channel SDRAM FIFO arbiter: round-robin write/read channel selection with
// write priority, read anti-starvation, and per-channel burst address generation.
module sdram_mc_fifo_arbiter #(
    parameter int NUM_CH     = 4,
    parameter int ADDR_W     = 24,
    parameter int LEN_W      = 10,
    parameter int USE_W      = 10,
    parameter int MAX_WR_RUN = 4
) (
    input  logic clk_ref,
    input  logic rst_n,
    sdram_mc_fifo_arbiter_if.master io_bus
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int RUN_W = $clog2(MAX_WR_RUN + 1);
    localparam int CW    = (USE_W > LEN_W) ? USE_W : LEN_W;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_BUSY, S_UPD} state_t;
    state_t r_state, w_state_nxt;

    logic [NUM_CH-1:0]             r_wl1, r_wl2, r_rl1, r_rl2, r_rv1, r_rv2;
    logic [NUM_CH-1:0]             w_wl_edge, w_rl_edge, w_wr_elig, w_rd_elig;
    logic [NUM_CH-1:0][ADDR_W-1:0] r_wr_addr, r_rd_addr;
    logic [NUM_CH-1:0]             r_bank, r_grant;
    logic [CH_W-1:0]               r_idx, r_wr_ptr, r_rd_ptr, w_wr_pick, w_rd_pick, w_idx;
    logic [RUN_W-1:0]              r_run_cnt;
    logic                          r_op_wr, r_ack_d, r_upd_kill;
    logic                          w_ack, w_any_wr, w_any_rd, w_pick_wr, w_start, w_upd;
    logic [ADDR_W-1:0]             w_cur, w_min, w_max, w_nxt_addr;
    logic [LEN_W-1:0]              w_len;
    logic [ADDR_W:0]               w_sum, w_lim;
    logic                          w_pp, w_fits, w_toggle;

    function automatic logic [CH_W-1:0] rr_pick(input logic [NUM_CH-1:0] req,
                                                 input logic [CH_W-1:0] ptr);
        logic [CH_W-1:0] pick;
        int              idx;
        pick = ptr;
        // Walk backwards so the channel closest after the pointer wins last.
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_CH;
            if (req[idx]) pick = CH_W'(idx);
        end
        return pick;
    endfunction

    function automatic logic [CH_W-1:0] ptr_inc(input logic [CH_W-1:0] p);
        return (p == CH_W'(NUM_CH - 1)) ? '0 : p + CH_W'(1);
    endfunction

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            r_wl1 <= '0; r_wl2 <= '0; r_rl1 <= '0; r_rl2 <= '0; r_rv1 <= '0; r_rv2 <= '0;
        end else begin
            r_wl1 <= io_bus.wr_load;    r_wl2 <= r_wl1;
            r_rl1 <= io_bus.rd_load;    r_rl2 <= r_rl1;
            r_rv1 <= io_bus.read_valid; r_rv2 <= r_rv1;
        end
    end

    assign w_wl_edge = r_wl1 & ~r_wl2;
    assign w_rl_edge = r_rl1 & ~r_rl2;

    always_comb begin
        w_wr_elig = '0;
        w_rd_elig = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_wr_elig[i] = (io_bus.wr_length[i] != '0) &&
                           (CW'(io_bus.wrf_use[i]) >= CW'(io_bus.wr_length[i]));
            w_rd_elig[i] = (io_bus.rd_length[i] != '0) && r_rv2[i] &&
                           (CW'(io_bus.rdf_use[i]) < CW'(io_bus.rd_length[i]));
        end
    end

    assign w_any_wr  = |w_wr_elig;
    assign w_any_rd  = |w_rd_elig;
    assign w_pick_wr = w_any_wr && !(w_any_rd && (r_run_cnt == RUN_W'(MAX_WR_RUN)));
    assign w_wr_pick = rr_pick(w_wr_elig, r_wr_ptr);
    assign w_rd_pick = rr_pick(w_rd_elig, r_rd_ptr);
    assign w_idx     = w_pick_wr ? w_wr_pick : w_rd_pick;
    assign w_ack     = r_op_wr ? io_bus.sdram_wr_ack : io_bus.sdram_rd_ack;

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            S_IDLE: if (io_bus.sdram_init_done && (w_any_wr || w_any_rd)) begin
                w_start     = 1'b1;
                w_state_nxt = S_REQ;
            end
            S_REQ:  if (w_ack) w_state_nxt = S_BUSY;
            S_BUSY: if (r_ack_d && !w_ack) w_state_nxt = S_UPD;
            S_UPD:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            r_grant <= '0; r_idx <= '0; r_op_wr <= 1'b0; r_ack_d <= 1'b0; r_upd_kill <= 1'b0;
            r_wr_ptr <= '0; r_rd_ptr <= '0; r_run_cnt <= '0;
        end else begin
            r_ack_d <= w_ack;
            if (w_start) begin
                r_grant    <= NUM_CH'(1) << w_idx;
                r_idx      <= w_idx;
                r_op_wr    <= w_pick_wr;
                r_upd_kill <= 1'b0;
                if (w_pick_wr) begin
                    r_wr_ptr <= ptr_inc(w_wr_pick);
                    if (!w_any_rd)                              r_run_cnt <= '0;
                    else if (r_run_cnt != RUN_W'(MAX_WR_RUN))   r_run_cnt <= r_run_cnt + RUN_W'(1);
                end else begin
                    r_rd_ptr  <= ptr_inc(w_rd_pick);
                    r_run_cnt <= '0;
                end
            end else if (r_state != S_IDLE &&
                         (r_op_wr ? w_wl_edge[r_idx] : w_rl_edge[r_idx])) begin
                // A reload during the burst wins over the post-burst advance.
                r_upd_kill <= 1'b1;
            end
            if (r_state == S_BUSY && w_state_nxt == S_UPD) r_grant <= '0;
        end
    end

    always_comb begin
        w_cur = r_op_wr ? r_wr_addr[r_idx] : r_rd_addr[r_idx];
        w_len = r_op_wr ? io_bus.wr_length[r_idx] : io_bus.rd_length[r_idx];
        w_min = r_op_wr ? io_bus.wr_min_addr[r_idx] : io_bus.rd_min_addr[r_idx];
        w_max = r_op_wr ? io_bus.wr_max_addr[r_idx] : io_bus.rd_max_addr[r_idx];
        w_pp  = io_bus.pingpang_en[r_idx];
        if (w_pp) begin
            w_sum = {2'b00, w_cur[ADDR_W-2:0]} + (ADDR_W+1)'(w_len);
            w_lim = {2'b00, w_max[ADDR_W-2:0]};
        end else begin
            w_sum = {1'b0, w_cur} + (ADDR_W+1)'(w_len);
            w_lim = {1'b0, w_max};
        end
        w_fits     = w_sum < w_lim;
        w_nxt_addr = w_fits ? w_cur + ADDR_W'(w_len)
                   : w_pp   ? {~r_bank[r_idx], w_min[ADDR_W-2:0]} : w_min;
        w_toggle   = r_op_wr && w_pp && !w_fits;
    end

    assign w_upd = (r_state == S_UPD) && !r_upd_kill;

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_addr <= '0; r_rd_addr <= '0; r_bank <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_wl_edge[i]) begin
                    r_wr_addr[i] <= io_bus.wr_min_addr[i];
                    r_bank[i]    <= 1'b0;
                end else if (w_upd && r_op_wr && r_idx == CH_W'(i)) begin
                    r_wr_addr[i] <= w_nxt_addr;
                    if (w_toggle) r_bank[i] <= ~r_bank[i];
                end
                if (w_rl_edge[i])
                    r_rd_addr[i] <= io_bus.rd_min_addr[i];
                else if (w_upd && !r_op_wr && r_idx == CH_W'(i))
                    r_rd_addr[i] <= w_nxt_addr;
            end
        end
    end

    assign io_bus.sdram_wr_req  = (r_state == S_REQ) && r_op_wr;
    assign io_bus.sdram_rd_req  = (r_state == S_REQ) && !r_op_wr;
    assign io_bus.sdram_wr_addr = io_bus.sdram_wr_req ? r_wr_addr[r_idx] : '0;
    assign io_bus.sdram_rd_addr = io_bus.sdram_rd_req ? r_rd_addr[r_idx] : '0;
    assign io_bus.grant         = r_grant;
    assign io_bus.wrf_rdreq     = r_grant & {NUM_CH{io_bus.sdram_wr_ack}};
    assign io_bus.rdf_wrreq     = r_grant & {NUM_CH{io_bus.sdram_rd_ack}};
endmodule

// File: tb/tb_sdram_mc_fifo_arbiter.sv
// Directed bench for sdram_mc_fifo_arbiter: small SDRAM ack model plus
// hand-computed grant/address expectations per burst.
module tb_sdram_mc_fifo_arbiter;
    logic clk_ref = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   w;

    sdram_mc_fifo_arbiter_if #(.NUM_CH(4), .ADDR_W(24), .LEN_W(10), .USE_W(10)) bus ();

    sdram_mc_fifo_arbiter #(.NUM_CH(4), .ADDR_W(24), .LEN_W(10), .USE_W(10), .MAX_WR_RUN(4)) dut (
        .clk_ref (clk_ref),
        .rst_n   (rst_n),
        .io_bus  (bus)
    );

    always #5 clk_ref = ~clk_ref;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wait for a request, check it, then ack for n cycles; optional wr_load pulse mid-burst.
    task automatic burst(input bit wr, input int n, input logic [3:0] eg, input logic [23:0] ea,
                         input int ld, input string tag, output int waited);
        waited = 0;
        @(negedge clk_ref);
        while (!(wr ? bus.sdram_wr_req : bus.sdram_rd_req) && waited < 40) begin
            @(negedge clk_ref);
            waited++;
        end
        check({tag, ":req"}, 32'(wr ? bus.sdram_wr_req : bus.sdram_rd_req), 32'd1);
        if (waited >= 40) return;
        check({tag, ":gnt"}, 32'(bus.grant), 32'(eg));
        check({tag, ":addr"}, 32'(wr ? bus.sdram_wr_addr : bus.sdram_rd_addr), 32'(ea));
        @(posedge clk_ref); #1;
        if (wr) bus.sdram_wr_ack = 1'b1; else bus.sdram_rd_ack = 1'b1;
        @(negedge clk_ref);
        check({tag, ":strb"}, 32'(wr ? bus.wrf_rdreq : bus.rdf_wrreq), 32'(eg));
        for (int c = 1; c < n; c++) begin
            @(posedge clk_ref); #1;
            if (ld >= 0 && c == 1) bus.wr_load[ld] = 1'b1;
            if (ld >= 0 && c == 3) bus.wr_load[ld] = 1'b0;
        end
        @(posedge clk_ref); #1;
        bus.sdram_wr_ack = 1'b0;
        bus.sdram_rd_ack = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.sdram_init_done = 1'b0;
        bus.wr_load = '0; bus.rd_load = '0; bus.read_valid = '0; bus.pingpang_en = '0;
        bus.wr_length = '0; bus.rd_length = '0; bus.wrf_use = '0; bus.rdf_use = '0;
        bus.sdram_wr_ack = 1'b0; bus.sdram_rd_ack = 1'b0;
        bus.wr_min_addr[0] = 24'h0;    bus.wr_min_addr[1] = 24'h1000;
        bus.wr_min_addr[2] = 24'h100;  bus.wr_min_addr[3] = 24'h3000;
        for (int i = 0; i < 4; i++) begin
            bus.wr_max_addr[i] = bus.wr_min_addr[i] + 24'h1000;
            bus.rd_min_addr[i] = 24'h0;
            bus.rd_max_addr[i] = 24'h10;
        end
        bus.rd_min_addr[1] = 24'h2000; bus.rd_max_addr[1] = 24'h3000;

        repeat (3) @(posedge clk_ref);
        @(negedge clk_ref);
        check("rst:wr_req", 32'(bus.sdram_wr_req), 32'd0);
        check("rst:rd_req", 32'(bus.sdram_rd_req), 32'd0);
        check("rst:grant", 32'(bus.grant), 32'd0);
        check("rst:wr_addr", 32'(bus.sdram_wr_addr), 32'd0);
        check("rst:rd_addr", 32'(bus.sdram_rd_addr), 32'd0);
        @(posedge clk_ref); #1 rst_n = 1'b1;
        @(posedge clk_ref); #1 bus.wr_load = '1; bus.rd_load = '1;
        repeat (2) @(posedge clk_ref); #1 bus.wr_load = '0; bus.rd_load = '0;
        repeat (3) @(posedge clk_ref); #1 bus.sdram_init_done = 1'b1;

        // Round-robin across ch0, ch1, ch3 writes
        bus.wr_length[0] = 10'd4; bus.wr_length[1] = 10'd4; bus.wr_length[3] = 10'd4;
        bus.wrf_use[0] = 10'd4;   bus.wrf_use[1] = 10'd4;   bus.wrf_use[3] = 10'd4;
        burst(1, 4, 4'b0001, 24'h0,    -1, "rr0", w);
        burst(1, 4, 4'b0010, 24'h1000, -1, "rr1", w);
        burst(1, 4, 4'b1000, 24'h3000, -1, "rr3", w);
        burst(1, 4, 4'b0001, 24'h4,    -1, "rr0b", w);
        bus.wrf_use = '0;

        // Ch2 threshold, latency and address advance
        bus.wr_length[2] = 10'd8; bus.wrf_use[2] = 10'd7;
        repeat (5) @(posedge clk_ref);
        @(negedge clk_ref);
        check("t1:below_thr", 32'(bus.sdram_wr_req), 32'd0);
        @(posedge clk_ref); #1 bus.wrf_use[2] = 10'd8;
        @(negedge clk_ref);
        check("t1:lat_pre", 32'(bus.sdram_wr_req), 32'd0);
        burst(1, 8, 4'b0100, 24'h100, -1, "t1a", w);
        check("t1:lat", 32'(w), 32'd0);
        burst(1, 8, 4'b0100, 24'h108, -1, "t1b", w);
        bus.wrf_use = '0;

        // Anti-starvation: 4 writes then the ch1 read
        bus.rd_length[1] = 10'd4; bus.rdf_use[1] = 10'd4; bus.read_valid[1] = 1'b1;
        repeat (4) @(posedge clk_ref); #1;
        bus.rdf_use[1] = 10'd0;
        bus.wrf_use[0] = 10'd8; bus.wrf_use[1] = 10'd8; bus.wrf_use[2] = 10'd8; bus.wrf_use[3] = 10'd8;
        burst(1, 4, 4'b1000, 24'h3004, -1, "as_w3", w);
        burst(1, 4, 4'b0001, 24'h8,    -1, "as_w0", w);
        burst(1, 4, 4'b0010, 24'h1004, -1, "as_w1", w);
        burst(1, 8, 4'b0100, 24'h110,  -1, "as_w2", w);
        burst(0, 4, 4'b0010, 24'h2000, -1, "as_rd", w);
        bus.wrf_use = '0; bus.rdf_use[1] = 10'd4; bus.read_valid[1] = 1'b0;

        // Ping-pong on ch0
        bus.pingpang_en[0] = 1'b1;
        bus.wr_max_addr[0] = 24'h20; bus.wr_length[0] = 10'h10;
        bus.rd_length[0] = 10'h10;   bus.rdf_use[0] = 10'h10;
        @(posedge clk_ref); #1 bus.wr_load[0] = 1'b1; bus.rd_load[0] = 1'b1;
        repeat (2) @(posedge clk_ref); #1 bus.wr_load[0] = 1'b0; bus.rd_load[0] = 1'b0;
        repeat (3) @(posedge clk_ref); #1 bus.wrf_use[0] = 10'h10;
        burst(1, 4, 4'b0001, 24'h0,      -1, "pp_w0", w);
        burst(1, 4, 4'b0001, 24'h10,     -1, "pp_w1", w);
        burst(1, 4, 4'b0001, 24'h800000, -1, "pp_w2", w);
        bus.wrf_use = '0;
        bus.read_valid[0] = 1'b1; bus.rdf_use[0] = 10'h0;
        burst(0, 4, 4'b0001, 24'h0, -1, "pp_r0", w);
        burst(0, 4, 4'b0001, 24'h0, -1, "pp_r1", w);
        bus.rdf_use[0] = 10'h10;

        // wr_load on ch3 mid-burst: no advance afterwards
        bus.wrf_use[3] = 10'd4;
        burst(1, 6, 4'b1000, 24'h3008, 3, "ld_a", w);
        burst(1, 4, 4'b1000, 24'h3000, -1, "ld_b", w);
        bus.wrf_use = '0;

        // Async reset mid-REQ, then init_done gating
        bus.wrf_use[1] = 10'd8;
        @(negedge clk_ref);
        w = 0;
        while (!bus.sdram_wr_req && w < 40) begin @(negedge clk_ref); w++; end
        check("r6:req_seen", 32'(bus.sdram_wr_req), 32'd1);
        rst_n = 1'b0; bus.wrf_use = '0; bus.sdram_init_done = 1'b0;
        #1;
        check("r6:wr_req", 32'(bus.sdram_wr_req), 32'd0);
        check("r6:grant", 32'(bus.grant), 32'd0);
        check("r6:wr_addr", 32'(bus.sdram_wr_addr), 32'd0);
        @(posedge clk_ref); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk_ref); #1 bus.wrf_use[1] = 10'd8;
        repeat (5) @(posedge clk_ref);
        @(negedge clk_ref);
        check("r6:init_gate", 32'(bus.sdram_wr_req), 32'd0);
        check("r6:idle_gnt", 32'(bus.grant), 32'd0);
        @(posedge clk_ref); #1 bus.sdram_init_done = 1'b1;
        burst(1, 4, 4'b0010, 24'h0, -1, "r6_post", w);
        bus.wrf_use = '0;
        repeat (4) @(posedge clk_ref);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
